control_fsm: RTL

- Multicycle controller sitting directly upstream of the processor datapath.
- Fetches 16-bit instructions over a req/ack memory handshake and holds them in an internal instruction register that feeds the datapath's instruction input.
- Sequences every datapath enable and mux select, latches ALU flags, and resolves conditional branches.

---
 rtl/control_fsm.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle fetch/decode/execute controller for the processor datapath
module control_fsm #(
    parameter int PC_INC = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] memdata,
    input  logic        mem_ack,
    input  logic        alu_c,
    input  logic        alu_l,
    input  logic        alu_f,
    input  logic        alu_z,
    input  logic        alu_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic [15:0] instruction,
    output logic [3:0]  aluControl,
    output logic        pcRegEn,
    output logic        srcRegEn,
    output logic        dstRegEn,
    output logic        immRegEn,
    output logic        resultRegEn,
    output logic        signEn,
    output logic        regFileEn,
    output logic        pcRegMuxEn,
    output logic        shiftALUMuxEn,
    output logic        regImmMuxEn,
    output logic        exMemResultEn,
    output logic [1:0]  mux4En,
    output logic [4:0]  psr
);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_WB, S_MEM, S_LOAD_WB, S_BRANCH
    } state_t;

    typedef enum logic [2:0] {
        K_NOP, K_ALU, K_ALUI, K_SHIFT, K_LOAD, K_STOR, K_BRANCH
    } kind_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic [3:0] alu;
        logic       pc_en;
        logic       src_en;
        logic       dst_en;
        logic       imm_en;
        logic       res_en;
        logic       sign_en;
        logic       rf_en;
        logic       pc_mux;
        logic       shift_mux;
        logic       reg_imm_mux;
        logic       ex_mem_result;
        logic [1:0] mux4;
    } ctl_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    // A zero increment is served by the datapath's constant-zero input.
    localparam logic [1:0] MUX4_PC = (PC_INC == 0) ? 2'd3 : 2'd2;

    function automatic logic is_alu_code(input logic [3:0] code);
        return code inside {4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
    endfunction

    function automatic logic [3:0] alu_op(input logic [3:0] code);
        case (code)
            4'h9, 4'hB: return 4'b0001;
            4'h1:       return 4'b0010;
            4'h2:       return 4'b0011;
            4'h3:       return 4'b0100;
            4'hD:       return 4'b0101;
            default:    return ALU_ADD;
        endcase
    endfunction

    function automatic kind_t classify(input logic [3:0] op, input logic [3:0] ext);
        kind_t k;
        k = K_NOP;
        case (op)
            4'b0000: if (is_alu_code(ext)) k = K_ALU;
            4'b0100: begin
                if (ext == 4'b0000) k = K_LOAD;
                else if (ext == 4'b0100) k = K_STOR;
            end
            4'b1000: if (ext == 4'b0100 || ext[3:1] == 3'b000) k = K_SHIFT;
            4'b1100: k = K_BRANCH;
            default: if (is_alu_code(op)) k = K_ALUI;
        endcase
        return k;
    endfunction

    function automatic ctl_t drive(input state_t st, input logic [15:4] f,
                                   input logic z, input logic l);
        ctl_t  c;
        kind_t k;
        logic  taken;
        c = '0;
        k = classify(f[15:12], f[7:4]);
        case (f[11:8])
            4'b0000: taken = z;
            4'b0001: taken = !z;
            4'b1100: taken = l;
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        case (st)
            S_FETCH: c.mem_req = 1'b1;
            S_DECODE: begin
                c.src_en = 1'b1;
                c.dst_en = 1'b1;
                c.imm_en = 1'b1;
                c.mux4   = MUX4_PC;
                c.alu    = ALU_ADD;
                c.pc_en  = 1'b1;
            end
            S_EXEC: begin
                c.pc_mux = 1'b1;
                c.res_en = 1'b1;
                if (k == K_SHIFT) begin
                    c.shift_mux   = 1'b1;
                    c.reg_imm_mux = (f[7:4] != 4'b0100);
                end else begin
                    c.alu = alu_op((k == K_ALUI) ? f[15:12] : f[7:4]);
                    if (k == K_ALUI) begin
                        c.sign_en = 1'b1;
                        c.mux4    = 2'd1;
                    end
                end
            end
            S_WB: c.rf_en = 1'b1;
            S_MEM: begin
                c.mem_req      = 1'b1;
                c.mem_addr_sel = 1'b1;
                c.mem_we       = (k == K_STOR);
            end
            S_LOAD_WB: begin
                c.rf_en         = 1'b1;
                c.ex_mem_result = 1'b1;
            end
            S_BRANCH: if (taken) begin
                c.sign_en = 1'b1;
                c.mux4    = 2'd1;
                c.alu     = ALU_ADD;
                c.pc_en   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t      state, nxt;
    kind_t       kind;
    logic [3:0]  fcode;
    logic [15:0] ir, ir_nxt;
    ctl_t        ctl;

    always_comb begin
        kind   = classify(ir[15:12], ir[7:4]);
        fcode  = (kind == K_ALUI) ? ir[15:12] : ir[7:4];
        nxt    = state;
        ir_nxt = ir;
        case (state)
            S_RESET: nxt = S_FETCH;
            S_FETCH: if (mem_ack) begin
                nxt    = S_DECODE;
                ir_nxt = memdata;
            end
            S_DECODE: case (kind)
                K_ALU, K_ALUI, K_SHIFT: nxt = S_EXEC;
                K_LOAD, K_STOR:         nxt = S_MEM;
                K_BRANCH:               nxt = S_BRANCH;
                default:                nxt = S_FETCH;
            endcase
            S_EXEC: nxt = (kind != K_SHIFT && fcode == 4'hB) ? S_FETCH : S_WB;
            S_MEM: if (mem_ack) nxt = (kind == K_LOAD) ? S_LOAD_WB : S_FETCH;
            default: nxt = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so each state's controls are glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RESET;
            ir    <= '0;
            psr   <= '0;
            ctl   <= '0;
        end else begin
            state <= nxt;
            ir    <= ir_nxt;
            ctl   <= drive(nxt, ir_nxt[15:4], psr[1], psr[3]);
            if (state == S_EXEC && kind != K_SHIFT && fcode inside {4'h5, 4'h9, 4'hB})
                psr <= {alu_c, alu_l, alu_f, alu_z, alu_n};
        end
    end

    assign instruction   = ir;
    assign mem_req       = ctl.mem_req;
    assign mem_we        = ctl.mem_we;
    assign mem_addr_sel  = ctl.mem_addr_sel;
    assign aluControl    = ctl.alu;
    assign pcRegEn       = ctl.pc_en;
    assign srcRegEn      = ctl.src_en;
    assign dstRegEn      = ctl.dst_en;
    assign immRegEn      = ctl.imm_en;
    assign resultRegEn   = ctl.res_en;
    assign signEn        = ctl.sign_en;
    assign regFileEn     = ctl.rf_en;
    assign pcRegMuxEn    = ctl.pc_mux;
    assign shiftALUMuxEn = ctl.shift_mux;
    assign regImmMuxEn   = ctl.reg_imm_mux;
    assign exMemResultEn = ctl.ex_mem_result;
    assign mux4En        = ctl.mux4;

endmodule
